// File: rtl/pow2_arbiter.sv
// pow2_arbiter: shares one 2**A evaluation unit between NREQ requesters.
// Round-robin grant, one request in flight at a time, registered result
// presented on a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        per-requester request, held until its gnt bit is seen
//   a_in       flattened exponents, requester i at [i*AW +: AW]
//   gnt        one-hot, one-cycle acceptance pulse (IDLE only)
//   busy       high whenever the FSM is not in IDLE
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_data   2**A truncated to OW bits, 0 on overflow
//   out_id     index of the served requester
//   out_ovf    high when A >= OW
module pow2_arbiter #(
   parameter  int NREQ = 4,
   parameter  int AW   = 7,
   parameter  int OW   = 7,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] a_in,
   output logic [NREQ-1:0]    gnt,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OW-1:0]      out_data,
   output logic [IW-1:0]      out_id,
   output logic               out_ovf
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] op_id;
   logic [AW-1:0] op_a;
   logic [IW-1:0] win_id;
   logic [IW-1:0] idx;
   logic          win_any;
   logic [AW-1:0] a_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = a_in[i*AW +: AW];
   end

   // First set req bit searching upward from rr_ptr, wrapping at NREQ.
   always_comb begin
      win_any = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((int'(rr_ptr) + k) % NREQ);
         if (!win_any && req[idx]) begin
            win_any = 1'b1;
            win_id  = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      case (state)
         IDLE: if (win_any) begin
            state_nxt = CALC;
            // Grant is combinational; suppressed while reset is held.
            if (!rst) gnt[win_id] = 1'b1;
         end
         CALC: state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_a      <= '0;
         op_id     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (win_any) begin
               op_a  <= a_arr[win_id];
               op_id <= win_id;
            end
            CALC: begin
               // Shift only when in range so no bits wrap into the result.
               if (int'(op_a) < OW) begin
                  out_data <= OW'(1) << op_a;
                  out_ovf  <= 1'b0;
               end else begin
                  out_data <= '0;
                  out_ovf  <= 1'b1;
               end
               out_id    <= op_id;
               out_valid <= 1'b1;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               // Pointer advances on hand-off only, never at grant.
               rr_ptr    <= (op_id == IW'(NREQ-1)) ? '0 : op_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pow2_arbiter.sv
// Self-checking bench for pow2_arbiter: directed scenarios plus randomized
// transactions, checked against a behavioural round-robin/pow2 model.
module tb_pow2_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 7;
   localparam int OW   = 7;
   localparam int IW   = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*AW-1:0] a_in;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [OW-1:0]      out_data;
   logic [IW-1:0]      out_id;
   logic               out_ovf;

   logic [AW-1:0] a_val [NREQ];
   int vectors = 0;
   int miscompares = 0;
   int ref_ptr = 0;

   pow2_arbiter #(.NREQ(NREQ), .AW(AW), .OW(OW)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .gnt(gnt), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   always_comb begin
      a_in = '0;
      for (int i = 0; i < NREQ; i++) a_in[i*AW +: AW] = a_val[i];
   end

   // Round-robin rule: first requester at or after the pointer, cyclically.
   function automatic int ref_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [31:0] ref_data(input int a);
      if (a < OW) return 32'(2 ** a);
      return 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction starting in IDLE: grant, CALC, DONE (with optional
   // stall cycles), hand-off. Leaves the DUT in IDLE, 1ns after the edge.
   task automatic txn(input logic [NREQ-1:0] r, input bit drop, input int stall);
      int w;
      logic [31:0] ed;
      logic [31:0] eo;
      req = r;
      #1;
      w  = ref_pick(r, ref_ptr);
      ed = ref_data(int'(a_val[w]));
      eo = (int'(a_val[w]) >= OW) ? 32'd1 : 32'd0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("gnt", 32'(gnt), 32'(1 << w));
      tick();
      if (drop) req[w] = 1'b0;
      #1;
      chk("gnt_pulse", 32'(gnt), 32'd0);
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_valid", 32'(out_valid), 32'd0);
      if (stall > 0) out_ready = 1'b0;
      tick();
      for (int s = 0; s <= stall; s++) begin
         chk("valid", 32'(out_valid), 32'd1);
         chk("data", 32'(out_data), ed);
         chk("id", 32'(out_id), 32'(w));
         chk("ovf", 32'(out_ovf), eo);
         chk("done_gnt", 32'(gnt), 32'd0);
         chk("done_busy", 32'(busy), 32'd1);
         if (s == stall) out_ready = 1'b1;
         tick();
      end
      chk("handoff_valid", 32'(out_valid), 32'd0);
      chk("handoff_busy", 32'(busy), 32'd0);
      ref_ptr = (w + 1) % NREQ;
   endtask

   initial begin
      int bvals [4];
      logic [31:0] ed;
      bvals = '{6, 7, 127, 0};
      foreach (a_val[i]) a_val[i] = '0;

      // Reset state; gnt must stay low while rst is high even with requests.
      rst = 1'b1;
      req = '1;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_id", 32'(out_id), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req = '0;
      rst = 1'b0;
      ref_ptr = 0;
      tick();
      chk("idle_nogrant", 32'(gnt), 32'd0);

      // Single request, A=3 -> 8.
      a_val[1] = 7'd3;
      txn(4'b0010, 1'b1, 0);

      // Boundary exponents on requester 2.
      for (int i = 0; i < 4; i++) begin
         a_val[2] = AW'(bvals[i]);
         txn(4'b0100, 1'b1, int'($urandom_range(0, 2)));
      end

      // Round-robin from a fresh pointer: 0,1,2,3 with 3-cycle spacing.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ref_ptr = 0;
      foreach (a_val[i]) a_val[i] = AW'($urandom_range(0, 9));
      out_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         chk("rr_order", 32'(ref_pick(4'(4'b1111 << i), ref_ptr)), 32'(i));
         txn(4'(4'b1111 << i), 1'b1, 0);
      end
      // req0 and req2 held continuously: alternate 0,2,0,2.
      for (int i = 0; i < 4; i++) txn(4'b0101, 1'b0, 0);
      req = '0;

      // Backpressure: requester 0 result held 5 cycles while req3 waits.
      a_val[0] = 7'd5;
      ed = ref_data(5);
      req = 4'b0001;
      #1;
      chk("bp_gnt0", 32'(gnt), 32'b0001);
      tick();
      req = 4'b0000;
      out_ready = 1'b0;
      tick();
      req = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), ed);
         chk("bp_id", 32'(out_id), 32'd0);
         chk("bp_gnt", 32'(gnt), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      ref_ptr = 1;
      chk("bp_release_gnt", 32'(gnt), 32'b1000);
      txn(4'b1000, 1'b1, 0);

      // Reset during CALC; pending req2 granted right after release.
      a_val[1] = 7'd2;
      req = 4'b0010;
      #1;
      tick();
      rst = 1'b1;
      req = 4'b0100;
      #1;
      chk("rstc_gnt", 32'(gnt), 32'd0);
      tick();
      chk("rstc_valid", 32'(out_valid), 32'd0);
      chk("rstc_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      ref_ptr = 0;
      txn(4'b0100, 1'b1, 0);

      // Reset during DONE; pointer must restart at 0 (req1 beats req2).
      req = 4'b1000;
      #1;
      tick();
      req = 4'b0000;
      out_ready = 1'b0;
      tick();
      chk("rstd_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      req = 4'b0110;
      tick();
      chk("rstd_valid", 32'(out_valid), 32'd0);
      chk("rstd_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      ref_ptr = 0;
      txn(4'b0110, 1'b1, 0);
      txn(4'b0100, 1'b1, 0);

      // Withdrawn request: req1 pulses only while DONE, never granted.
      a_val[0] = 7'd1;
      req = 4'b0001;
      #1;
      chk("wd_gnt0", 32'(gnt), 32'b0001);
      tick();
      req = 4'b0000;
      out_ready = 1'b0;
      tick();
      req = 4'b0010;
      #1;
      chk("wd_done_gnt", 32'(gnt), 32'd0);
      chk("wd_id", 32'(out_id), 32'd0);
      chk("wd_data", 32'(out_data), ref_data(1));
      tick();
      req = 4'b0000;
      tick();
      out_ready = 1'b1;
      tick();
      ref_ptr = 1;
      for (int i = 0; i < 3; i++) begin
         chk("wd_idle_gnt", 32'(gnt), 32'd0);
         chk("wd_idle_busy", 32'(busy), 32'd0);
         tick();
      end
      txn(4'b1000, 1'b1, 0);

      // Randomized transactions.
      for (int n = 0; n < 24; n++) begin
         foreach (a_val[i]) a_val[i] = ($urandom_range(0, 3) == 0) ?
            AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 8));
         txn(NREQ'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
      end
      req = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
